// File: rtl/core_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// core_ctrl_pkg
//
// Shared definitions for the core_controller register bus.
//   - ctrl_state_e    : state encoding of the command-to-AXI master FSM
//   - REG_* / CTRL_*  : register map of the core_controller slave
//   - AXI_RESP_*      : AXI4-Lite response codes
//   - AXI_PROT_DEFAULT: protection attribute driven on AW/AR
//   - is_wait_state() : true for states that wait on a slave handshake
// ---------------------------------------------------------------------------
package core_ctrl_pkg;

    // Master FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_RESP  = 3'd5
    } ctrl_state_e;

    // core_controller register offsets (byte addresses)
    localparam logic [15:0] REG_CTRL     = 16'h0000;
    localparam logic [15:0] REG_MEM_ADDR = 16'h0004;
    localparam logic [15:0] REG_STAT     = 16'h0008;

    // Bit positions inside the CTRL register
    localparam int CTRL_RST_BIT  = 0;
    localparam int CTRL_EXEC_BIT = 1;

    // AXI response codes
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Unprivileged, secure, data access
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // States in which the master is blocked on the slave and the
    // wait timer is running.
    function automatic logic is_wait_state(input ctrl_state_e s);
        logic result;
        case (s)
            ST_WADDR, ST_WRESP, ST_RADDR, ST_RDATA: result = 1'b1;
            default:                                result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/axi_wait_timer.sv
// ---------------------------------------------------------------------------
// axi_wait_timer
//
// Saturating counter of consecutive stall cycles inside one bus-wait state,
// with a sticky flag that rises once the count reaches C_TIMEOUT.
//
// Ports:
//   clk     in  clock, rising edge
//   rst     in  asynchronous active-high reset
//   clear   in  restart the count (entry into a new wait state)
//   stall   in  this cycle is spent waiting without leaving the state
//   timeout out sticky flag, cleared only by reset
// ---------------------------------------------------------------------------
module axi_wait_timer #(
    parameter int C_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic stall,
    output logic timeout
);

    localparam int CW = $clog2(C_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(C_TIMEOUT);

    logic [CW-1:0] count_q, count_d;
    logic          timeout_q, timeout_d;

    // Next count: restart on entry, count stalls, hold once saturated.
    // The flag is set in the same update that brings the count to the
    // limit, so it becomes visible in the cycle after the limit is reached.
    always_comb begin
        count_d   = count_q;
        timeout_d = timeout_q;
        if (clear) begin
            count_d = '0;
        end else if (stall && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
        if (count_d == LIMIT) begin
            timeout_d = 1'b1;
        end
    end

    // Counter and sticky flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;

endmodule

// File: rtl/core_controller_master.sv
// ---------------------------------------------------------------------------
// core_controller_master
//
// AXI4-Lite master turning a one-outstanding command/response interface into
// single-beat AXI4-Lite reads and writes toward core_controller. Every bus
// wait is watched by axi_wait_timer; a hung slave raises the sticky TIMEOUT
// flag without aborting the transaction.
//
// Ports:
//   M_AXI_ACLK / M_AXI_ARST  clock / async active-high reset
//   CMD_*                    command in (VALID/READY, WRITE, ADDR, WDATA, WSTRB)
//   RSP_*                    response out (VALID/READY, RDATA, RESP)
//   TIMEOUT                  sticky wait-timeout flag
//   M_AXI_AW*/W*/B*/AR*/R*   AXI4-Lite master channels
// All outputs are registered except CMD_READY, decoded from state.
// ---------------------------------------------------------------------------
module core_controller_master
    import core_ctrl_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 16,
    parameter int C_TIMEOUT          = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARST,

    input  logic                              CMD_VALID,
    output logic                              CMD_READY,
    input  logic                              CMD_WRITE,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     CMD_ADDR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     CMD_WDATA,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   CMD_WSTRB,

    output logic                              RSP_VALID,
    input  logic                              RSP_READY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     RSP_RDATA,
    output logic [1:0]                        RSP_RESP,

    output logic                              TIMEOUT,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,

    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;

    ctrl_state_e   state_q, state_d;

    logic [AW-1:0] awaddr_q, awaddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic [AW-1:0] araddr_q, araddr_d;

    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;

    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]    rsp_resp_q, rsp_resp_d;

    logic          aw_done, w_done;
    logic          timer_clear, timer_stall, timeout_flag;

    // AW and W finish independently; a channel whose VALID has already
    // dropped counts as finished.
    assign aw_done = !awvalid_q || M_AXI_AWREADY;
    assign w_done  = !wvalid_q  || M_AXI_WREADY;

    // Next-state and next-output logic. Every registered output holds its
    // value by default, so a VALID and its payload stay put until the
    // matching handshake, regardless of the timeout flag.
    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        araddr_d    = araddr_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    if (CMD_WRITE) begin
                        awaddr_d  = CMD_ADDR;
                        wdata_d   = CMD_WDATA;
                        wstrb_d   = CMD_WSTRB;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WADDR;
                    end else begin
                        araddr_d  = CMD_ADDR;
                        arvalid_d = 1'b1;
                        state_d   = ST_RADDR;
                    end
                end
            end

            ST_WADDR: begin
                if (awvalid_q && M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && M_AXI_WREADY) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = ST_WRESP;
                end
            end

            ST_WRESP: begin
                if (M_AXI_BVALID) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = M_AXI_BRESP;
                    state_d     = ST_RESP;
                end
            end

            ST_RADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RDATA;
                end
            end

            ST_RDATA: begin
                if (M_AXI_RVALID) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_resp_d  = M_AXI_RRESP;
                    state_d     = ST_RESP;
                end
            end

            ST_RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops every VALID/READY at once
    // and discards any command in flight.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARST) begin
        if (M_AXI_ARST) begin
            state_q     <= ST_IDLE;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            araddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= AXI_RESP_OKAY;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            araddr_q    <= araddr_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // The timer restarts whenever a new wait state is entered and counts
    // only cycles in which the current wait state is not left.
    assign timer_clear = (state_d != state_q) && is_wait_state(state_d);
    assign timer_stall = is_wait_state(state_q) && (state_d == state_q);

    axi_wait_timer #(
        .C_TIMEOUT (C_TIMEOUT)
    ) u_wait_timer (
        .clk     (M_AXI_ACLK),
        .rst     (M_AXI_ARST),
        .clear   (timer_clear),
        .stall   (timer_stall),
        .timeout (timeout_flag)
    );

    // Ready for a command only in IDLE and never while reset is held
    assign CMD_READY     = (state_q == ST_IDLE) && !M_AXI_ARST;

    assign RSP_VALID     = rsp_valid_q;
    assign RSP_RDATA     = rsp_rdata_q;
    assign RSP_RESP      = rsp_resp_q;
    assign TIMEOUT       = timeout_flag;

    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
